local_field_accumulator: RTL and testbench
==========================================

# local_field_accumulator

Streaming signed accumulator that builds the Ising local field h = Σ s_j·J_ij for one spin from a stream of (weight, spin) terms. The result is saturated to int16 and presented on a valid/ready output. That output feeds the combinational int16_to_fp16 converter directly, so the int16 result is what the floating-point datapath downstream receives. Each result window covers exactly N_TERMS accepted terms, with a counter marking the window boundary.

## Interface
- N_TERMS, 16: accepted terms per result window; must be ≥ 2.
- W_WIDTH, 16: width of the signed two's-complement input weight, ≤ 16.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  a term is presented.
- in_ready  out  1  block accepts a term this cycle.
- in_weight  in  W_WIDTH  signed weight J_ij.
- in_spin  in  1  spin s_j: 1 adds +in_weight, 0 adds −in_weight.
- out_valid  out  1  result held on out_sum.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  16  signed saturated local field.
- out_sat  out  1  out_sum was clamped.

## Operation
- Internal accumulator acc is signed and ACC_W = W_WIDTH + clog2(N_TERMS) + 1 bits wide. It never overflows, and negating −2^(W_WIDTH−1) is exact.
- term = in_spin ? sext(in_weight) : −sext(in_weight), computed at ACC_W.
- A term is accepted when in_valid && in_ready. Cycles with in_valid=0 are bubbles and are not counted.
- cnt counts accepted terms in the current window, from 0 to N_TERMS−1.
- The FSM has two states, ACCUM and HOLD.
- ACCUM:
  - in_ready=1.
  - On accept with cnt < N_TERMS−1: acc ← acc + term; cnt ← cnt+1.
  - On accept with cnt = N_TERMS−1: final = acc + term.
    - out_sum ← clamp(final, −32768, 32767).
    - out_sat ← (final > 32767) || (final < −32768).
    - out_valid ← 1; acc ← 0; cnt ← 0; go to HOLD.
- HOLD:
  - in_ready=0; in_valid and in_weight are ignored.
  - out_sum and out_sat are held stable.
  - On out_valid && out_ready: out_valid ← 0; go to ACCUM.
- rst:
  - Next state is ACCUM; acc=0, cnt=0.
  - out_valid=0, out_sum=0, out_sat=0.
  - Any partial window or undelivered result is discarded.
- in_ready = (state==ACCUM) && !rst.
- in_ready depends only on state, so there is no combinational path from out_ready to in_ready.

## Timing
- Reset values: out_valid=0, out_sum=16'h0000, out_sat=0. in_ready=0 during rst and 1 in the first cycle after rst deasserts.
- Latency: out_valid rises in the cycle after the N_TERMS-th accept edge.
- With out_ready tied high, the handshake completes in that first valid cycle. in_ready returns in the following cycle.
- Peak throughput is one result per N_TERMS+1 cycles.
- Output follows the valid/ready rules:
  - Once asserted, out_valid stays high until handshake.
  - out_sum and out_sat do not change while out_valid=1.
- out_ready is don't-care while out_valid=0.
- rst asserted in the same cycle as an accept or a handshake: rst wins, and neither the term nor the result takes effect.
- Saturation boundaries:
  - final = 32767 gives out_sat=0; 32768 gives out_sum=32767, out_sat=1.
  - final = −32768 gives out_sat=0; −32769 gives out_sum=−32768, out_sat=1.

## Test plan
- Basic sum, N_TERMS=4: terms (10,1), (20,1), (−5,1), (7,0) back-to-back → one cycle after the 4th accept: out_sum=18, out_sat=0, in_ready=0. The converter output for 18 is 16'h4C80.
- Positive saturation, N_TERMS=16: sixteen terms (32767,1) → out_sum=32767, out_sat=1, converter 16'h7800. Sixteen terms (−32768,0) → out_sum=32767, out_sat=1.
- Negative saturation and exact boundary, N_TERMS=16:
  - Sixteen terms (−32768,1) → out_sum=−32768, out_sat=1, converter 16'hF800.
  - Terms (−32768,1) then fifteen (0,1) → out_sum=−32768, out_sat=0.
- Bubbles and backpressure, N_TERMS=4:
  - Terms (1,1) ×4 with in_valid low for 3 cycles between each → out_sum=4.
  - Hold out_ready=0 for 5 cycles → out_valid, out_sum=4 and in_ready=0 stay stable while in_valid=1 is ignored.
  - Then out_ready=1 → handshake, and in_ready=1 the next cycle.
- Reset mid-window, N_TERMS=4:
  - Accept (100,1) ×3, then pulse rst for 1 cycle.
  - Then (1,1), (2,1), (3,1), (4,0) → out_sum=2, with no trace of the discarded 300.
  - rst while out_valid=1 → out_valid=0 and out_sum=0 on the next cycle.
- Back-to-back windows, N_TERMS=2, out_ready=1, in_valid=1 continuously with alternating weights 5,−3,7,7 and spin=1:
  - Results are 2 then 14.
  - in_ready is low exactly one cycle per window.
  - No term is lost or double-counted.

Source files
------------

// File: rtl/local_field_accumulator.sv
// rtl/local_field_accumulator.sv - streaming Ising local-field accumulator with int16 saturation and fp16 converter

// Combinational int16 -> IEEE fp16 conversion, round-to-nearest-even.
// Every int16 magnitude lands in the normal range, so subnormals and infinity never occur.
module int16_to_fp16 (
    input  logic [15:0] value,
    output logic [15:0] fp16
);

    logic        sign;
    logic [15:0] mag;
    logic [3:0]  msb;
    logic [15:0] norm;
    logic        round_up;
    logic [10:0] mant_r;
    logic [4:0]  exp_f;

    // Normalise the magnitude, round the bits below the 10-bit mantissa, rebias the exponent
    always_comb begin
        fp16     = 16'h0000;
        sign     = value[15];
        mag      = sign ? (~value + 16'd1) : value;
        msb      = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (mag[i]) begin
                msb = 4'(i);
            end
        end
        norm     = mag << (4'd15 - msb);
        round_up = norm[4] & (norm[5] | (|norm[3:0]));
        mant_r   = {1'b0, norm[14:5]} + {10'd0, round_up};
        exp_f    = 5'd15 + {1'b0, msb} + {4'd0, mant_r[10]};
        if (mag != 16'd0) begin
            fp16 = {sign, exp_f, mant_r[9:0]};
        end
    end

endmodule

module local_field_accumulator #(
    parameter int N_TERMS = 16,
    parameter int W_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_WIDTH-1:0] in_weight,
    input  logic               in_spin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_sum,
    output logic               out_sat
);

    // One guard bit beyond the worst-case growth keeps -(-2^(W-1)) and full windows exact
    localparam int ACC_W = W_WIDTH + $clog2(N_TERMS) + 1;
    localparam int CNT_W = $clog2(N_TERMS);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          cnt;
    logic signed [ACC_W-1:0]   weight_ext;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   sum_next;
    logic signed [31:0]        sum_wide;
    logic                      accept;
    logic                      last_term;
    logic                      sat_hi;
    logic                      sat_lo;
    logic [15:0]               clamped;

    assign in_ready   = (state == ACCUM) && !rst;
    assign out_valid  = (state == HOLD);
    assign accept     = in_valid && in_ready;
    assign last_term  = (cnt == CNT_W'(N_TERMS - 1));

    assign weight_ext = {{(ACC_W - W_WIDTH){in_weight[W_WIDTH-1]}}, in_weight};
    assign term       = in_spin ? weight_ext : -weight_ext;
    assign sum_next   = acc + term;
    assign sum_wide   = {{(32 - ACC_W){sum_next[ACC_W-1]}}, sum_next};

    // Clamp the finished window total to the int16 range seen by the fp16 datapath
    always_comb begin
        sat_hi  = (sum_wide > 32'sd32767);
        sat_lo  = (sum_wide < -32'sd32768);
        clamped = sum_wide[15:0];
        if (sat_hi) begin
            clamped = 16'h7FFF;
        end else if (sat_lo) begin
            clamped = 16'h8000;
        end
    end

    // State register; reset drops any pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Close a window on its last accepted term, release it on the output handshake
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (accept && last_term) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Accumulate accepted terms and latch the saturated result at the window boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            out_sum <= 16'h0000;
            out_sat <= 1'b0;
        end else if (accept) begin
            if (last_term) begin
                acc     <= '0;
                cnt     <= '0;
                out_sum <= clamped;
                out_sat <= sat_hi || sat_lo;
            end else begin
                acc     <= sum_next;
                cnt     <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_local_field_accumulator.sv
// tb/tb_local_field_accumulator.sv - directed self-checking bench for local_field_accumulator
`timescale 1ns/1ps

module tb_local_field_accumulator;

    logic        clk;
    logic        rst;

    logic        va, ra, sa, ova, ora, sata;
    logic [15:0] wa, suma, fpa;
    logic        vb, rb, sb, ovb, orb, satb;
    logic [15:0] wb, sumb, fpb;
    logic        vc, rc, sc, ovc, orc, satc;
    logic [15:0] wc, sumc;

    int tests_run;
    int tests_failed;

    local_field_accumulator #(.N_TERMS(4), .W_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_weight(wa), .in_spin(sa),
        .out_valid(ova), .out_ready(ora), .out_sum(suma), .out_sat(sata)
    );
    local_field_accumulator #(.N_TERMS(16), .W_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_weight(wb), .in_spin(sb),
        .out_valid(ovb), .out_ready(orb), .out_sum(sumb), .out_sat(satb)
    );
    local_field_accumulator #(.N_TERMS(2), .W_WIDTH(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(vc), .in_ready(rc), .in_weight(wc), .in_spin(sc),
        .out_valid(ovc), .out_ready(orc), .out_sum(sumc), .out_sat(satc)
    );
    int16_to_fp16 conv_a (.value(suma), .fp16(fpa));
    int16_to_fp16 conv_b (.value(sumb), .fp16(fpb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [15:0] w, input logic s);
        va = 1'b1; wa = w; sa = s;
        tick();
        va = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] w, input logic s);
        vb = 1'b1; wb = w; sb = s;
        tick();
        vb = 1'b0;
    endtask

    task automatic check_b(input string name, input logic [15:0] exp_sum, input logic exp_sat);
        tests_run++;
        if (ovb !== 1'b1 || sumb !== exp_sum || satb !== exp_sat) begin
            tests_failed++;
            $display("FAIL %s: valid=%b sum=%h sat=%b, expected valid=1 sum=%h sat=%b",
                     name, ovb, sumb, satb, exp_sum, exp_sat);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({ra, rb, rc} !== 3'b000 || {ova, ovb, ovc} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready_valid: ready=%b valid=%b, expected 000/000", {ra, rb, rc}, {ova, ovb, ovc});
        end
        tests_run++;
        if (suma !== 16'h0000 || sumb !== 16'h0000 || sumc !== 16'h0000 || {sata, satb, satc} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_sum_sat: sums=%h/%h/%h sat=%b, expected 0000 and 000", suma, sumb, sumc, {sata, satb, satc});
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({ra, rb, rc} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_release_ready: ready=%b, expected 111", {ra, rb, rc});
        end
    endtask

    task automatic test_basic_sum();
        ora = 1'b1;
        send_a(16'd10, 1'b1);
        send_a(16'd20, 1'b1);
        send_a(-16'sd5, 1'b1);
        send_a(16'd7, 1'b0);
        tests_run++;
        if (ova !== 1'b1 || suma !== 16'd18 || sata !== 1'b0 || ra !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_sum: valid=%b sum=%0d sat=%b ready=%b, expected 1 18 0 0", ova, $signed(suma), sata, ra);
        end
        tests_run++;
        if (fpa !== 16'h4C80) begin
            tests_failed++;
            $display("FAIL basic_fp16: got %h, expected 4c80", fpa);
        end
        tick();
        tests_run++;
        if (ova !== 1'b0 || ra !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_handshake: valid=%b ready=%b, expected 0 1", ova, ra);
        end
    endtask

    task automatic test_saturation();
        orb = 1'b1;
        for (int i = 0; i < 16; i++) send_b(16'h7FFF, 1'b1);
        tests_run++;
        if (fpb !== 16'h7800) begin
            tests_failed++;
            $display("FAIL pos_sat_fp16: got %h, expected 7800", fpb);
        end
        check_b("pos_sat_max", 16'h7FFF, 1'b1);
        for (int i = 0; i < 16; i++) send_b(16'h8000, 1'b0);
        check_b("pos_sat_negmin", 16'h7FFF, 1'b1);
        for (int i = 0; i < 16; i++) send_b(16'h8000, 1'b1);
        tests_run++;
        if (fpb !== 16'hF800) begin
            tests_failed++;
            $display("FAIL neg_sat_fp16: got %h, expected f800", fpb);
        end
        check_b("neg_sat_min", 16'h8000, 1'b1);
        send_b(16'h8000, 1'b1);
        for (int i = 0; i < 15; i++) send_b(16'h0000, 1'b1);
        check_b("neg_exact_boundary", 16'h8000, 1'b0);
        send_b(16'h7FFF, 1'b1);
        for (int i = 0; i < 15; i++) send_b(16'h0000, 1'b1);
        check_b("pos_exact_boundary", 16'h7FFF, 1'b0);
        send_b(16'h7FFF, 1'b1);
        send_b(16'h0001, 1'b1);
        for (int i = 0; i < 14; i++) send_b(16'h0000, 1'b0);
        check_b("pos_one_over", 16'h7FFF, 1'b1);
        send_b(16'h8000, 1'b1);
        send_b(16'h0001, 1'b0);
        for (int i = 0; i < 14; i++) send_b(16'h0000, 1'b1);
        check_b("neg_one_over", 16'h8000, 1'b1);
    endtask

    task automatic test_bubbles_backpressure();
        ora = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_a(16'd1, 1'b1);
            if (i < 3) begin
                tick(); tick(); tick();
            end
        end
        tests_run++;
        if (ova !== 1'b1 || suma !== 16'd4 || sata !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubbles_sum: valid=%b sum=%0d sat=%b, expected 1 4 0", ova, $signed(suma), sata);
        end
        va = 1'b1; wa = 16'd99; sa = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (ova !== 1'b1 || suma !== 16'd4 || ra !== 1'b0) begin
                tests_failed++;
                $display("FAIL backpressure_hold_%0d: valid=%b sum=%0d ready=%b, expected 1 4 0", i, ova, $signed(suma), ra);
            end
        end
        va = 1'b0;
        ora = 1'b1;
        tick();
        tests_run++;
        if (ova !== 1'b0 || ra !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: valid=%b ready=%b, expected 0 1", ova, ra);
        end
        for (int i = 0; i < 4; i++) send_a(16'd2, 1'b1);
        tests_run++;
        if (ova !== 1'b1 || suma !== 16'd8) begin
            tests_failed++;
            $display("FAIL after_hold_window: valid=%b sum=%0d, expected 1 8", ova, $signed(suma));
        end
        tick();
    endtask

    task automatic test_reset_mid_window();
        ora = 1'b1;
        for (int i = 0; i < 3; i++) send_a(16'd100, 1'b1);
        va = 1'b1; wa = 16'd100; sa = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        va = 1'b0;
        send_a(16'd1, 1'b1);
        send_a(16'd2, 1'b1);
        send_a(16'd3, 1'b1);
        send_a(16'd4, 1'b0);
        tests_run++;
        if (ova !== 1'b1 || suma !== 16'd2 || sata !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_window: valid=%b sum=%0d sat=%b, expected 1 2 0", ova, $signed(suma), sata);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (ova !== 1'b0 || suma !== 16'd0 || sata !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_while_valid: valid=%b sum=%0d sat=%b, expected 0 0 0", ova, $signed(suma), sata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] wlist [4];
        int          k;
        int          low_cycles;
        int          nres;
        logic [15:0] res [2];
        logic        rdy;
        wlist[0] = 16'd5; wlist[1] = -16'sd3; wlist[2] = 16'd7; wlist[3] = 16'd7;
        k = 0; low_cycles = 0; nres = 0;
        res[0] = 16'hxxxx; res[1] = 16'hxxxx;
        orc = 1'b1; sc = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            rdy = rc;
            if (!rdy) low_cycles++;
            vc = (k < 4);
            wc = (k < 4) ? wlist[k] : 16'd0;
            tick();
            if (rdy && vc) k++;
            if (ovc === 1'b1) begin
                if (nres < 2) res[nres] = sumc;
                nres++;
            end
        end
        vc = 1'b0;
        tests_run++;
        if (nres != 2 || res[0] !== 16'd2 || res[1] !== 16'd14) begin
            tests_failed++;
            $display("FAIL b2b_results: count=%0d r0=%0d r1=%0d, expected 2 results 2 and 14", nres, $signed(res[0]), $signed(res[1]));
        end
        tests_run++;
        if (low_cycles != 2 || k != 4) begin
            tests_failed++;
            $display("FAIL b2b_ready_low: low_cycles=%0d consumed=%0d, expected 2 and 4", low_cycles, k);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        va = 1'b0; wa = '0; sa = 1'b0; ora = 1'b1;
        vb = 1'b0; wb = '0; sb = 1'b0; orb = 1'b1;
        vc = 1'b0; wc = '0; sc = 1'b0; orc = 1'b1;
        test_reset();
        test_basic_sum();
        test_saturation();
        test_bubbles_backpressure();
        test_reset_mid_window();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
